key_debounce_multi: RTL

Parametrised N-channel push-button conditioner for board keys. Each channel synchronises an asynchronous raw key and debounces it with a restartable stability counter. It outputs a normalised debounced level plus single-cycle press, release and long-press pulses. It sits between board key pins and control FSMs (mode select, speed up/down), replacing per-key level-only debouncers.

---
 rtl/key_debounce_multi.sv | 106 ++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N-channel key synchroniser/debouncer with level, press, release and long-press outputs.
module key_debounce_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 180000,
  parameter int LONG_CYCLES     = 25000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);
  localparam int MAXC = DEBOUNCE_CYCLES > LONG_CYCLES ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] DB_END = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LG_END = LONG_CYCLES == 0 ? '0 : CW'(LONG_CYCLES - 1);
  localparam logic LONG_EN = LONG_CYCLES != 0;
  localparam logic REL_LVL = ACTIVE_LOW != 0;
  typedef enum logic [2:0] {RELEASED, PRESS_CHK, PRESSED, LONG_HELD, REL_CHK} state_t;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [SYNC_STAGES-1:0] sync_q;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic long_done_q, long_done_d;
    logic press_q, press_d, release_q, release_d, long_q, long_d;
    logic s;
    // XOR with the released level maps the pin to 1 = pressed for either polarity
    assign s = sync_q[SYNC_STAGES-1] ^ REL_LVL;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + ONE;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q      <= {SYNC_STAGES{REL_LVL}};
        state_q     <= RELEASED;
        cnt_q       <= '0;
        long_done_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        sync_q      <= {sync_q[SYNC_STAGES-2:0], key_in[k]};
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        long_done_q <= long_done_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
      end
    end
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      long_done_d = long_done_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      case (state_q)
        RELEASED: if (s) begin
          state_d = PRESS_CHK;
          cnt_d   = ONE;
        end
        PRESS_CHK: if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_END) begin
          state_d     = PRESSED;
          cnt_d       = '0;
          press_d     = 1'b1;
          long_done_d = 1'b0;
        end else cnt_d = cnt_inc;
        PRESSED: if (!s) begin
          state_d = REL_CHK;
          cnt_d   = ONE;
        end else if (LONG_EN && cnt_q == LG_END) begin
          state_d     = LONG_HELD;
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end else cnt_d = cnt_inc;
        LONG_HELD: if (!s) begin
          state_d = REL_CHK;
          cnt_d   = ONE;
        end
        REL_CHK: if (s) begin
          state_d = long_done_q ? LONG_HELD : PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_END) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else cnt_d = cnt_inc;
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
    assign key_level[k]   = state_q inside {PRESSED, LONG_HELD, REL_CHK};
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;
  end
endmodule
